// File: rtl/gnr_run_ctrl_pkg.sv
// Shared types and defaults for the GNR run controller.
package gnr_run_ctrl_pkg;

  localparam int GNR_N_NODES = 8;
  localparam int GNR_STEP_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_STEP   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } gnr_state_e;

endpackage

// File: rtl/gnr_run_ctrl_if.sv
// Host-side run request / result bundle of the GNR run controller.
interface gnr_run_ctrl_if
  import gnr_run_ctrl_pkg::*;
#(
  parameter int N_NODES = GNR_N_NODES,
  parameter int STEP_W  = GNR_STEP_W
);
  logic               start;
  logic [N_NODES-1:0] init_vec;
  logic [STEP_W-1:0]  max_steps;
  logic               busy;
  logic               done;
  logic               converged;
  logic               oscillating;
  logic [STEP_W-1:0]  steps;
  logic [N_NODES-1:0] final_state;

  modport master (
    output start, init_vec, max_steps,
    input  busy, done, converged, oscillating, steps, final_state
  );

  modport slave (
    input  start, init_vec, max_steps,
    output busy, done, converged, oscillating, steps, final_state
  );
endinterface

// File: rtl/gnr_run_ctrl_state_hist.sv
// lat_s1 history and fixed-point / period-2 comparators.
// GNR_CYCLE_DETECT_EN adds the second history register and the osc_o output.
module gnr_state_hist
  import gnr_run_ctrl_pkg::*;
#(
  parameter int N_NODES = GNR_N_NODES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [N_NODES-1:0] init_vec_i,
  input  logic [N_NODES-1:0] lat_s0_i,
  input  logic [N_NODES-1:0] lat_s1_i,
`ifdef GNR_CYCLE_DETECT_EN
  output logic               osc_o,
`endif
  output logic               fix_o
);
  logic [N_NODES-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else if (load_i) begin
      prev_q <= init_vec_i;
    end else if (shift_i) begin
      prev_q <= lat_s1_i;
    end
  end

  assign fix_o = (lat_s1_i == prev_q) && (lat_s0_i == lat_s1_i);

`ifdef GNR_CYCLE_DETECT_EN
  logic [N_NODES-1:0] prev2_q;
  logic               prev2_vld_q;

  // prev2 becomes meaningful after the first shift, i.e. from step 2 on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev2_q     <= '0;
      prev2_vld_q <= 1'b0;
    end else if (load_i) begin
      prev2_q     <= '0;
      prev2_vld_q <= 1'b0;
    end else if (shift_i) begin
      prev2_q     <= prev_q;
      prev2_vld_q <= 1'b1;
    end
  end

  assign osc_o = prev2_vld_q && !fix_o && (lat_s1_i == prev2_q) && (lat_s1_i != prev_q);
`endif
endmodule

// File: rtl/gnr_run_ctrl.sv
// Run controller: strobes a GNR node array until fixed point or step limit.
// Optional period-2 cycle detection under GNR_CYCLE_DETECT_EN.
module gnr_run_ctrl
  import gnr_run_ctrl_pkg::*;
#(
  parameter int N_NODES = GNR_N_NODES,
  parameter int STEP_W  = GNR_STEP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  gnr_run_ctrl_if.slave      host_if,
  input  logic [N_NODES-1:0] lat_s0_i,
  input  logic [N_NODES-1:0] lat_s1_i,
  output logic               reset_nos_o,
  output logic [N_NODES-1:0] init_state_o,
  output logic               start_s0_o,
  output logic               start_s1_o
);
  gnr_state_e         state_q;
  logic [N_NODES-1:0] init_q;
  logic [STEP_W-1:0]  max_q;
  logic [STEP_W-1:0]  steps_q;
  logic [N_NODES-1:0] final_q;
  logic [N_NODES-1:0] init_state_q;
  logic               busy_q, done_q, conv_q, reset_nos_q, strobe_q;
  logic               hist_fix;
`ifdef GNR_CYCLE_DETECT_EN
  logic               osc_q;
  logic               hist_osc;
`endif

  gnr_state_hist #(.N_NODES(N_NODES)) u_hist (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == ST_INIT),
    .shift_i    (state_q == ST_SAMPLE),
    .init_vec_i (init_q),
    .lat_s0_i   (lat_s0_i),
    .lat_s1_i   (lat_s1_i),
`ifdef GNR_CYCLE_DETECT_EN
    .osc_o      (hist_osc),
`endif
    .fix_o      (hist_fix)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      init_q       <= '0;
      max_q        <= '0;
      steps_q      <= '0;
      final_q      <= '0;
      init_state_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      conv_q       <= 1'b0;
      reset_nos_q  <= 1'b0;
      strobe_q     <= 1'b0;
`ifdef GNR_CYCLE_DETECT_EN
      osc_q        <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      reset_nos_q  <= 1'b0;
      strobe_q     <= 1'b0;
      init_state_q <= '0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE) final_q <= lat_s1_i;
          // a start in the DONE cycle wins over the final_state capture
          if (host_if.start) begin
            init_q       <= host_if.init_vec;
            max_q        <= host_if.max_steps;
            init_state_q <= host_if.init_vec;
            steps_q      <= '0;
            final_q      <= '0;
            conv_q       <= 1'b0;
`ifdef GNR_CYCLE_DETECT_EN
            osc_q        <= 1'b0;
`endif
            reset_nos_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_INIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_INIT: begin
          if (max_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            strobe_q <= 1'b1;
            state_q  <= ST_STEP;
          end
        end
        ST_STEP: begin
          steps_q <= steps_q + 1'b1;
          state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (hist_fix) begin
            conv_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`ifdef GNR_CYCLE_DETECT_EN
          end else if (hist_osc) begin
            osc_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
`endif
          end else if (steps_q == max_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            strobe_q <= 1'b1;
            state_q  <= ST_STEP;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reset_nos_o          = reset_nos_q;
  assign init_state_o         = init_state_q;
  assign start_s0_o           = strobe_q;
  assign start_s1_o           = strobe_q;
  assign host_if.busy         = busy_q;
  assign host_if.done         = done_q;
  assign host_if.converged    = conv_q;
  assign host_if.steps        = steps_q;
  assign host_if.final_state  = final_q;
`ifdef GNR_CYCLE_DETECT_EN
  assign host_if.oscillating  = osc_q;
`else
  assign host_if.oscillating  = 1'b0;
`endif
endmodule
